// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - multi-channel one-shot / periodic unit timer
//
// NCH independent timers sharing one clock. Each channel counts a programmed
// number of time units, where one unit is PERIOD = FCLK/SCALE clock cycles.
//
// Parameters
//   FCLK   clock frequency in Hz
//   SCALE  units per second (1 = s, 1000 = ms, 1000000 = us)
//   NCH    number of channels (1..32)
//   CW     unit counter width per channel
//
// Ports
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   start      in   NCH     per-channel start/restart strobe
//   stop       in   NCH     per-channel abort strobe
//   periodic   in   NCH     mode captured with start (1 = periodic)
//   value      in   NCH*CW  unit count captured with start, ch i at [i*CW +: CW]
//   done       out  NCH     one-cycle expiry pulse
//   busy       out  NCH     channel running
//   remaining  out  NCH*CW  units left, ch i at [i*CW +: CW]; 0 when idle
//   irq        out  NCH     sticky expiry flags       (MULTI_TIMER_IRQ_EN only)
//   irq_clr    in   NCH     per-channel flag clear    (MULTI_TIMER_IRQ_EN only)
//
// Build option
//   MULTI_TIMER_IRQ_EN  when defined, adds the sticky irq flags and irq_clr.

module multi_timer #(
    parameter int FCLK  = 100000000,
    parameter int SCALE = 1000,
    parameter int NCH   = 4,
    parameter int CW    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    start,
    input  logic [NCH-1:0]    stop,
    input  logic [NCH-1:0]    periodic,
    input  logic [NCH*CW-1:0] value,
`ifdef MULTI_TIMER_IRQ_EN
    input  logic [NCH-1:0]    irq_clr,
    output logic [NCH-1:0]    irq,
`endif
    output logic [NCH-1:0]    done,
    output logic [NCH-1:0]    busy,
    output logic [NCH*CW-1:0] remaining
);

    localparam int PERIOD = FCLK / SCALE;
    // Prescaler width; a PERIOD of 1 still gets a 1-bit register that stays 0.
    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state_q [NCH];
    state_t        state_d [NCH];
    logic [PW-1:0] pre_q   [NCH];
    logic [PW-1:0] pre_d   [NCH];
    logic [CW-1:0] cnt_q   [NCH];
    logic [CW-1:0] cnt_d   [NCH];
    logic [CW-1:0] rld_q   [NCH];
    logic [CW-1:0] rld_d   [NCH];
    logic          mode_q  [NCH];
    logic          mode_d  [NCH];
    logic [NCH-1:0] done_q;
    logic [NCH-1:0] done_d;

    // Per-channel next state. Priority is start > stop > unit tick, so a start
    // or stop landing on an expiry edge swallows that expiry's done pulse.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            pre_d[i]   = pre_q[i];
            cnt_d[i]   = cnt_q[i];
            rld_d[i]   = rld_q[i];
            mode_d[i]  = mode_q[i];
            done_d[i]  = 1'b0;

            if (start[i]) begin
                if (value[i*CW +: CW] != '0) begin
                    rld_d[i]   = value[i*CW +: CW];
                    cnt_d[i]   = value[i*CW +: CW];
                    pre_d[i]   = '0;
                    mode_d[i]  = periodic[i];
                    state_d[i] = S_RUN;
                end else begin
                    // Zero-length request: answer immediately and park idle.
                    done_d[i]  = 1'b1;
                    cnt_d[i]   = '0;
                    pre_d[i]   = '0;
                    state_d[i] = S_IDLE;
                end
            end else if (stop[i]) begin
                cnt_d[i]   = '0;
                pre_d[i]   = '0;
                state_d[i] = S_IDLE;
            end else if (state_q[i] == S_RUN) begin
                if (pre_q[i] == PRE_MAX) begin
                    pre_d[i] = '0;
                    if (cnt_q[i] > CNT_ONE) begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end else begin
                        done_d[i] = 1'b1;
                        if (mode_q[i]) begin
                            // Reload on the expiry edge itself so periodic
                            // pulses are exactly N*PERIOD apart.
                            cnt_d[i] = rld_q[i];
                        end else begin
                            cnt_d[i]   = '0;
                            state_d[i] = S_IDLE;
                        end
                    end
                end else begin
                    pre_d[i] = pre_q[i] + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= S_IDLE;
                pre_q[i]   <= '0;
                cnt_q[i]   <= '0;
                rld_q[i]   <= '0;
                mode_q[i]  <= 1'b0;
            end
            done_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                pre_q[i]   <= pre_d[i];
                cnt_q[i]   <= cnt_d[i];
                rld_q[i]   <= rld_d[i];
                mode_q[i]  <= mode_d[i];
            end
            done_q <= done_d;
        end
    end

    // Outputs come straight from flops; cnt is already 0 whenever idle.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            busy[i]                = (state_q[i] == S_RUN);
            remaining[i*CW +: CW]  = cnt_q[i];
        end
    end

    assign done = done_q;

`ifdef MULTI_TIMER_IRQ_EN
    logic [NCH-1:0] irq_q;
    logic [NCH-1:0] irq_d;

    // Set is taken from the same edge that raises done and beats a clear.
    always_comb begin
        irq_d = done_d | (irq_q & ~irq_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - directed table-driven bench for multi_timer

module tb_multi_timer;

    localparam int NCH = 4;
    localparam int CW  = 8;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    start;
    logic [NCH-1:0]    stop;
    logic [NCH-1:0]    periodic;
    logic [NCH*CW-1:0] value;
    logic [NCH-1:0]    done;
    logic [NCH-1:0]    busy;
    logic [NCH*CW-1:0] remaining;
`ifdef MULTI_TIMER_IRQ_EN
    logic [NCH-1:0]    irq_clr;
    logic [NCH-1:0]    irq;
`endif

    multi_timer #(
        .FCLK (10),
        .SCALE(1),
        .NCH  (NCH),
        .CW   (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .value    (value),
`ifdef MULTI_TIMER_IRQ_EN
        .irq_clr  (irq_clr),
        .irq      (irq),
`endif
        .done     (done),
        .busy     (busy),
        .remaining(remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // One record: strobes applied on the first edge, then cyc edges total;
    // outputs checked after the last edge, mid = OR of done on earlier edges.
    typedef struct {
        string          name;
        logic [NCH-1:0] st;
        logic [NCH-1:0] sp;
        logic [NCH-1:0] per;
        logic [31:0]    val;
        int             cyc;
        logic [NCH-1:0] exp_done;
        logic [NCH-1:0] exp_busy;
        logic [31:0]    exp_rem;
        logic [NCH-1:0] exp_mid;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic [3:0] st, input logic [3:0] sp,
                       input logic [3:0] per, input logic [31:0] val, input int cyc,
                       input logic [3:0] ed, input logic [3:0] eb,
                       input logic [31:0] er, input logic [3:0] em);
        vec_t v;
        v.name = nm; v.st = st; v.sp = sp; v.per = per; v.val = val; v.cyc = cyc;
        v.exp_done = ed; v.exp_busy = eb; v.exp_rem = er; v.exp_mid = em;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [NCH-1:0] mid;
        mid      = '0;
        start    = v.st;
        stop     = v.sp;
        periodic = v.per;
        value    = v.val;
        for (int c = 0; c < v.cyc; c++) begin
            step();
            start = '0;
            stop  = '0;
            if (c < v.cyc - 1) mid = mid | done;
        end
        check({v.name, ".done"}, 32'(done), 32'(v.exp_done));
        check({v.name, ".busy"}, 32'(busy), 32'(v.exp_busy));
        check({v.name, ".remaining"}, remaining, v.exp_rem);
        if (v.cyc > 1) check({v.name, ".mid_done"}, 32'(mid), 32'(v.exp_mid));
        periodic = '0;
        value    = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NCH-1:0] seen;

        rst_n = 1'b0; start = '0; stop = '0; periodic = '0; value = '0;
`ifdef MULTI_TIMER_IRQ_EN
        irq_clr = '0;
`endif

        // One-shot ch0, N=3; junk value/periodic mid-run must be ignored.
        add("os_start",   4'b0001, 0, 0,     32'h3,        1,  0, 4'b0001, 32'h3, 0);
        add("os_unit1",   0,       0, 4'hF,  32'hFFFFFFFF, 10, 0, 4'b0001, 32'h2, 0);
        add("os_unit2",   0,       0, 0,     0,            10, 0, 4'b0001, 32'h1, 0);
        add("os_pre",     0,       0, 0,     0,            9,  0, 4'b0001, 32'h1, 0);
        add("os_expire",  0,       0, 0,     0,            1,  4'b0001, 0, 0, 0);
        add("os_after",   0,       0, 0,     0,            1,  0, 0, 0, 0);
        // Zero value: immediate done, never busy, periodic ignored.
        add("zero_start", 4'b0100, 0, 4'b0100, 0,          1,  4'b0100, 0, 0, 0);
        add("zero_after", 0,       0, 0,     0,            1,  0, 0, 0, 0);
        // Periodic ch1, N=2, stopped at cycle 45.
        add("per_start",  4'b0010, 0, 4'b0010, 32'h200,    1,  0, 4'b0010, 32'h200, 0);
        add("per_pre",    0,       0, 0,     0,            19, 0, 4'b0010, 32'h100, 0);
        add("per_exp20",  0,       0, 0,     0,            1,  4'b0010, 4'b0010, 32'h200, 0);
        add("per_gap",    0,       0, 0,     0,            1,  0, 4'b0010, 32'h200, 0);
        add("per_exp40",  0,       0, 0,     0,            19, 4'b0010, 4'b0010, 32'h200, 0);
        add("per_run44",  0,       0, 0,     0,            4,  0, 4'b0010, 32'h200, 0);
        add("per_stop45", 0, 4'b0010, 0,     0,            1,  0, 0, 0, 0);
        add("per_quiet",  0,       0, 0,     0,            25, 0, 0, 0, 0);
        // Restart ch0 with 5 at cycle 25 of a 3-unit run.
        add("rs_start",   4'b0001, 0, 0,     32'h3,        1,  0, 4'b0001, 32'h3, 0);
        add("rs_run24",   0,       0, 0,     0,            24, 0, 4'b0001, 32'h1, 0);
        add("rs_restart", 4'b0001, 0, 0,     32'h5,        1,  0, 4'b0001, 32'h5, 0);
        add("rs_no30",    0,       0, 0,     0,            10, 0, 4'b0001, 32'h4, 0);
        add("rs_pre",     0,       0, 0,     0,            39, 0, 4'b0001, 32'h1, 0);
        add("rs_exp75",   0,       0, 0,     0,            1,  4'b0001, 0, 0, 0);
        // Start and stop on one edge restarts; stop on expiry edge is silent.
        add("ss_start",   4'b1000, 4'b1000, 0, 32'h04000000, 1, 0, 4'b1000, 32'h04000000, 0);
        add("ss_pre",     0,       0, 0,     0,            39, 0, 4'b1000, 32'h01000000, 0);
        add("ss_stopexp", 0, 4'b1000, 0,     0,            1,  0, 0, 0, 0);
        add("ss_quiet",   0,       0, 0,     0,            3,  0, 0, 0, 0);
        // Start on an expiry edge restarts with no done.
        add("se_start",   4'b0001, 0, 0,     32'h1,        1,  0, 4'b0001, 32'h1, 0);
        add("se_pre",     0,       0, 0,     0,            9,  0, 4'b0001, 32'h1, 0);
        add("se_restart", 4'b0001, 0, 0,     32'h2,        1,  0, 4'b0001, 32'h2, 0);
        add("se_exp",     0,       0, 0,     0,            20, 4'b0001, 0, 0, 0);
        // All four channels concurrently, N = 1,2,3,4.
        add("cc_start",   4'hF,    0, 0,     32'h04030201, 1,  0, 4'hF, 32'h04030201, 0);
        add("cc_t10",     0,       0, 0,     0,            10, 4'b0001, 4'hE, 32'h03020100, 0);
        add("cc_t20",     0,       0, 0,     0,            10, 4'b0010, 4'hC, 32'h02010000, 0);
        add("cc_t30",     0,       0, 0,     0,            10, 4'b0100, 4'h8, 32'h01000000, 0);
        add("cc_t40",     0,       0, 0,     0,            10, 4'b1000, 0, 0, 0);

        // Reset state.
        step(); step();
        check("rst.done", 32'(done), 32'h0);
        check("rst.busy", 32'(busy), 32'h0);
        check("rst.remaining", remaining, 32'h0);
`ifdef MULTI_TIMER_IRQ_EN
        check("rst.irq", 32'(irq), 32'h0);
`endif
        rst_n = 1'b1;
        step();

        foreach (vecs[k]) run_vec(vecs[k]);

        // Asynchronous reset on a cycle where done[1] is high.
        start = 4'b0011; periodic = 4'b0010; value = 32'h00000103;
        step();
        start = '0; periodic = '0; value = '0;
        repeat (10) step();
        check("arst.pre_done", 32'(done), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("arst.done", 32'(done), 32'h0);
        check("arst.busy", 32'(busy), 32'h0);
        check("arst.remaining", remaining, 32'h0);
        step();
        rst_n = 1'b1;
        seen = '0;
        for (int c = 0; c < 40; c++) begin
            step();
            seen = seen | done | busy;
        end
        check("arst.quiet", 32'(seen), 32'h0);

`ifdef MULTI_TIMER_IRQ_EN
        // Sticky flag: set by expiry, held, then cleared.
        start = 4'b0001; value = 32'h1;
        step();
        start = '0; value = '0;
        repeat (10) step();
        check("irq.set", 32'(irq), 32'h1);
        repeat (5) step();
        check("irq.hold", 32'(irq), 32'h1);
        irq_clr = 4'b0001;
        step();
        irq_clr = '0;
        check("irq.clear", 32'(irq), 32'h0);
        // Clear coinciding with a new done: set wins.
        start = 4'b0001; periodic = 4'b0001; value = 32'h1;
        step();
        start = '0; periodic = '0; value = '0;
        repeat (9) step();
        irq_clr = 4'b0001;
        step();
        irq_clr = '0;
        check("irq.set_wins.done", 32'(done), 32'h1);
        check("irq.set_wins", 32'(irq), 32'h1);
        stop = 4'b0001;
        step();
        stop = '0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
